// File: rtl/ifetch_if.sv
// Fetch-stage bus: icache request/response, commit-side redirect and the
// instruction-queue head presented to the decoder. master = fetch stage.
interface ifetch_if;
    logic        to_icache;
    logic [31:0] pc;
    logic        have_result;
    logic [31:0] inst;
    logic        clear;
    logic [31:0] clear_pc;
    logic        iq_ready;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_is_c;
    logic        iq_pred_taken;
    logic [31:0] iq_pred_pc;

    modport master (
        output to_icache, pc, iq_valid, iq_inst, iq_pc, iq_is_c, iq_pred_taken, iq_pred_pc,
        input  have_result, inst, clear, clear_pc, iq_ready
    );

    modport slave (
        input  to_icache, pc, iq_valid, iq_inst, iq_pc, iq_is_c, iq_pred_taken, iq_pred_pc,
        output have_result, inst, clear, clear_pc, iq_ready
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding icache request, compressed/full-width
// classification, static next-PC prediction and a small instruction FIFO.
module ifetch #(
    parameter int unsigned IQ_WIDTH = 3,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    ifetch_if.master bus
);
    localparam int unsigned IQ_DEPTH = 1 << IQ_WIDTH;

    localparam logic [IQ_WIDTH:0]   DEPTH_CNT = {1'b1, {IQ_WIDTH{1'b0}}};
    localparam logic [IQ_WIDTH:0]   ZERO_CNT  = {(IQ_WIDTH + 1){1'b0}};
    localparam logic [IQ_WIDTH-1:0] ZERO_PTR  = {IQ_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_ISSUE = 1'b0,
        ST_WAIT  = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        is_c;
        logic        pred_taken;
        logic [31:0] pred_pc;
    } iq_entry_t;

    localparam iq_entry_t EMPTY_ENTRY = '{
        inst: 32'h0000_0000, pc: 32'h0000_0000, is_c: 1'b0,
        pred_taken: 1'b0, pred_pc: 32'h0000_0000
    };

    // Build a queue entry from a returned word: size class and static prediction.
    function automatic iq_entry_t predict(input logic [31:0] fetch_pc, input logic [31:0] raw);
        iq_entry_t   e;
        logic [31:0] j_imm;
        logic [31:0] b_imm;
        j_imm        = {{11{raw[31]}}, raw[31], raw[19:12], raw[20], raw[30:21], 1'b0};
        b_imm        = {{19{raw[31]}}, raw[31], raw[7], raw[30:25], raw[11:8], 1'b0};
        e.pc         = fetch_pc;
        e.is_c       = (raw[1:0] != 2'b11);
        e.inst       = e.is_c ? {16'h0000, raw[15:0]} : raw;
        e.pred_taken = 1'b0;
        e.pred_pc    = fetch_pc + (e.is_c ? 32'd2 : 32'd4);
        if (!e.is_c && (raw[6:0] == 7'b1101111)) begin
            e.pred_taken = 1'b1;
            e.pred_pc    = fetch_pc + j_imm;
        end else if (!e.is_c && (raw[6:0] == 7'b1100011) && raw[31]) begin
            e.pred_taken = 1'b1;
            e.pred_pc    = fetch_pc + b_imm;
        end else begin
            e.pred_taken = 1'b0;
        end
        return e;
    endfunction

    state_e              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic                flush_pending_q, flush_pending_d;
    logic [31:0]         flush_pc_q, flush_pc_d;
    logic [IQ_WIDTH-1:0] head_q, head_d;
    logic [IQ_WIDTH-1:0] tail_q, tail_d;
    logic [IQ_WIDTH:0]   count_q, count_d;
    iq_entry_t           out_q, out_d;
    iq_entry_t           mem_q [IQ_DEPTH];

    logic      req_s;
    logic      push_s;
    logic      pop_s;
    logic      flush_s;
    iq_entry_t res_entry_s;
    iq_entry_t next_head_s;

    // Fetch FSM: request issue, result acceptance and redirect handling.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        flush_pending_d = flush_pending_q;
        flush_pc_d      = flush_pc_q;
        req_s           = 1'b0;
        push_s          = 1'b0;
        pop_s           = 1'b0;
        flush_s         = 1'b0;
        res_entry_s     = predict(pc_q, bus.inst);
        if (rdy) begin
            pop_s = bus.iq_ready && (count_q != ZERO_CNT) && !bus.clear;
            case (state_q)
                ST_ISSUE: begin
                    if (bus.clear) begin
                        flush_s = 1'b1;
                        pc_d    = bus.clear_pc;
                    end else if (count_q < DEPTH_CNT) begin
                        req_s   = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    // pc stays put here: the icache fills against the live pc.
                    if (bus.clear && bus.have_result) begin
                        flush_s         = 1'b1;
                        flush_pending_d = 1'b0;
                        pc_d            = bus.clear_pc;
                        state_d         = ST_ISSUE;
                    end else if (bus.clear) begin
                        flush_s         = 1'b1;
                        flush_pending_d = 1'b1;
                        flush_pc_d      = bus.clear_pc;
                    end else if (bus.have_result) begin
                        state_d = ST_ISSUE;
                        if (flush_pending_q) begin
                            flush_pending_d = 1'b0;
                            pc_d            = flush_pc_q;
                        end else begin
                            push_s = 1'b1;
                            pc_d   = res_entry_s.pred_pc;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_ISSUE;
                end
            endcase
        end else begin
            req_s = 1'b0;
        end
    end

    // Queue pointers, occupancy and the next registered head entry.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_s) begin
            head_d  = ZERO_PTR;
            tail_d  = ZERO_PTR;
            count_d = ZERO_CNT;
        end else begin
            head_d = pop_s ? head_q + 1'b1 : head_q;
            tail_d = push_s ? tail_q + 1'b1 : tail_q;
            if (push_s && !pop_s) begin
                count_d = count_q + 1'b1;
            end else if (pop_s && !push_s) begin
                count_d = count_q - 1'b1;
            end else begin
                count_d = count_q;
            end
        end
        // A push landing on the new head slot is not in storage yet; bypass it.
        next_head_s = (push_s && (head_d == tail_q)) ? res_entry_s : mem_q[head_d];
        if (count_d == ZERO_CNT) begin
            out_d = EMPTY_ENTRY;
        end else begin
            out_d = next_head_s;
        end
    end

    // Control and head-output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_ISSUE;
            pc_q            <= RESET_PC;
            flush_pending_q <= 1'b0;
            flush_pc_q      <= 32'h0000_0000;
            head_q          <= ZERO_PTR;
            tail_q          <= ZERO_PTR;
            count_q         <= ZERO_CNT;
            out_q           <= EMPTY_ENTRY;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            flush_pending_q <= flush_pending_d;
            flush_pc_q      <= flush_pc_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            out_q           <= out_d;
        end
    end

    // Queue storage; contents are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[tail_q] <= res_entry_s;
        end
    end

    // The request pulse is suppressed while reset is held.
    assign bus.to_icache     = req_s & rst;
    assign bus.pc            = pc_q;
    assign bus.iq_valid      = (count_q != ZERO_CNT);
    assign bus.iq_inst       = out_q.inst;
    assign bus.iq_pc         = out_q.pc;
    assign bus.iq_is_c       = out_q.is_c;
    assign bus.iq_pred_taken = out_q.pred_taken;
    assign bus.iq_pred_pc    = out_q.pred_pc;
endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: transaction-level fetch model checked every
// cycle, plus hand-computed request-address and head-entry expectations.
module tb_ifetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    ifetch_if bus ();

    ifetch #(.IQ_WIDTH(3), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        is_c;
        logic        taken;
        logic [31:0] pred;
    } ent_t;

    ent_t        mq[$];
    bit          m_wait, m_pend;
    logic [31:0] m_pc, m_ppc;
    int          n_chk, n_fail;
    bit   [31:0] mem [bit [31:0]];
    int          resp_cnt, miss_lat;
    logic [31:0] resp_pc;
    logic [31:0] req_log[$];
    int          idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string name, input int i, input logic [31:0] exp);
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        if (i < req_log.size()) v = req_log[i];
        chk(name, v, exp);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0000_0013;
    endfunction

    // What a fetched word at address a must become, from the ISA field layout.
    function automatic ent_t model_fetch(input logic [31:0] a, input logic [31:0] w);
        ent_t e;
        int   off;
        e.pc    = a;
        e.is_c  = (w[1:0] != 2'b11);
        e.inst  = e.is_c ? (w & 32'h0000_FFFF) : w;
        e.taken = 1'b0;
        e.pred  = a + (e.is_c ? 32'd2 : 32'd4);
        if (!e.is_c && w[6:0] == 7'h6F) begin
            off = (w[31] ? -(1 << 20) : 0) + (int'(w[19:12]) << 12)
                + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
            e.taken = 1'b1;
            e.pred  = a + 32'(off);
        end else if (!e.is_c && w[6:0] == 7'h63 && w[31]) begin
            off = -(1 << 12) + (int'(w[7]) << 11) + (int'(w[30:25]) << 5)
                + (int'(w[11:8]) << 1);
            e.taken = 1'b1;
            e.pred  = a + 32'(off);
        end
        return e;
    endfunction

    // One clock: drive icache response, compare, advance model, step to next negedge.
    task automatic cycle();
        bit   req;
        ent_t e;
        bus.have_result = 1'b0;
        if (resp_cnt > 0 && rdy) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                bus.have_result = 1'b1;
                bus.inst        = mem_rd(resp_pc);
            end
        end
        #1;
        req = rdy && !m_wait && (mq.size() < 8) && !bus.clear;
        chk("to_icache", bus.to_icache, req);
        chk("pc", bus.pc, m_pc);
        chk("iq_valid", bus.iq_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("iq_inst", bus.iq_inst, mq[0].inst);
            chk("iq_pc", bus.iq_pc, mq[0].pc);
            chk("iq_is_c", bus.iq_is_c, mq[0].is_c);
            chk("iq_pred_taken", bus.iq_pred_taken, mq[0].taken);
            chk("iq_pred_pc", bus.iq_pred_pc, mq[0].pred);
        end
        if (bus.to_icache) req_log.push_back(bus.pc);
        if (req) begin
            resp_cnt = miss_lat;
            resp_pc  = m_pc;
        end
        if (rdy) begin
            if (!m_wait) begin
                if (bus.clear) begin
                    m_pc = bus.clear_pc;
                    mq.delete();
                end else begin
                    if (req) m_wait = 1'b1;
                    if (bus.iq_ready && mq.size() > 0) void'(mq.pop_front());
                end
            end else if (bus.clear) begin
                mq.delete();
                if (bus.have_result) begin
                    m_wait = 1'b0;
                    m_pend = 1'b0;
                    m_pc   = bus.clear_pc;
                end else begin
                    m_pend = 1'b1;
                    m_ppc  = bus.clear_pc;
                end
            end else begin
                if (bus.iq_ready && mq.size() > 0) void'(mq.pop_front());
                if (bus.have_result) begin
                    m_wait = 1'b0;
                    if (m_pend) begin
                        m_pend = 1'b0;
                        m_pc   = m_ppc;
                    end else begin
                        e = model_fetch(m_pc, bus.inst);
                        mq.push_back(e);
                        m_pc = e.pred;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] t);
        req_log.delete();
        bus.clear    = 1'b1;
        bus.clear_pc = t;
        cycle();
        bus.clear    = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " to_icache"}, bus.to_icache, 32'd0);
        chk({tag, " pc"}, bus.pc, RESET_PC);
        chk({tag, " iq_valid"}, bus.iq_valid, 32'd0);
        chk({tag, " iq_inst"}, bus.iq_inst, 32'd0);
        chk({tag, " iq_pc"}, bus.iq_pc, 32'd0);
        chk({tag, " iq_is_c"}, bus.iq_is_c, 32'd0);
        chk({tag, " iq_pred_taken"}, bus.iq_pred_taken, 32'd0);
        chk({tag, " iq_pred_pc"}, bus.iq_pred_pc, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0; rdy = 1'b1;
        bus.have_result = 1'b0; bus.inst = 32'h0; bus.clear = 1'b0;
        bus.clear_pc = 32'h0; bus.iq_ready = 1'b0;
        miss_lat = 1; resp_cnt = 0; resp_pc = 32'h0;
        m_wait = 1'b0; m_pend = 1'b0; m_pc = RESET_PC; m_ppc = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Sequential hits of addi x0 (0x13) from the reset PC.
        req_log.delete();
        repeat (6) cycle();
        chk("seq nreq", req_log.size(), 32'd3);
        chk_log("seq req0", 0, 32'h0);
        chk_log("seq req1", 1, 32'h4);
        chk_log("seq req2", 2, 32'h8);
        chk("seq head0 pc", bus.iq_pc, 32'h0);
        chk("seq head0 pred", bus.iq_pred_pc, 32'h4);
        bus.iq_ready = 1'b1;
        cycle();
        chk("seq head1 pc", bus.iq_pc, 32'h4);
        chk("seq head1 pred", bus.iq_pred_pc, 32'h8);
        cycle();
        chk("seq head2 pc", bus.iq_pc, 32'h8);
        chk("seq head2 pred", bus.iq_pred_pc, 32'hC);
        bus.iq_ready = 1'b0;

        // Compressed word at 0x0 followed by a full-width one at 0x2.
        mem[32'h0] = 32'h0000_4501;
        redirect(32'h0);
        repeat (6) cycle();
        chk("mix head pc", bus.iq_pc, 32'h0);
        chk("mix head is_c", bus.iq_is_c, 32'd1);
        chk("mix head inst", bus.iq_inst, 32'h0000_4501);
        chk("mix head pred", bus.iq_pred_pc, 32'h2);
        bus.iq_ready = 1'b1;
        cycle();
        bus.iq_ready = 1'b0;
        chk("mix second pc", bus.iq_pc, 32'h2);
        chk("mix second pred", bus.iq_pred_pc, 32'h6);

        // JAL, backward branch, forward branch.
        mem[32'h100] = 32'h0100_006F;
        redirect(32'h100);
        repeat (6) cycle();
        chk_log("jal req0", 0, 32'h100);
        chk_log("jal req1", 1, 32'h110);
        chk("jal taken", bus.iq_pred_taken, 32'd1);
        chk("jal pred", bus.iq_pred_pc, 32'h110);

        mem[32'h200] = 32'hFE00_0EE3;
        redirect(32'h200);
        repeat (6) cycle();
        chk_log("bwd req0", 0, 32'h200);
        chk_log("bwd req1", 1, 32'h1FC);
        chk("bwd taken", bus.iq_pred_taken, 32'd1);
        chk("bwd pred", bus.iq_pred_pc, 32'h1FC);

        mem[32'h200] = 32'h0000_0463;
        redirect(32'h200);
        repeat (6) cycle();
        chk_log("fwd req0", 0, 32'h200);
        chk_log("fwd req1", 1, 32'h204);
        chk("fwd taken", bus.iq_pred_taken, 32'd0);
        chk("fwd pred", bus.iq_pred_pc, 32'h204);

        // Fill the 8-entry queue, then free one slot.
        redirect(32'h400);
        repeat (24) cycle();
        chk("full nreq", req_log.size(), 32'd8);
        bus.iq_ready = 1'b1;
        cycle();
        bus.iq_ready = 1'b0;
        repeat (3) cycle();
        chk("full nreq after pop", req_log.size(), 32'd9);
        chk_log("full req8", 8, 32'h420);

        // Redirect during a 10-cycle miss at 0x40.
        redirect(32'h40);
        miss_lat = 10;
        cycle();
        miss_lat = 1;
        repeat (3) cycle();
        bus.clear = 1'b1; bus.clear_pc = 32'h80;
        cycle();
        bus.clear = 1'b0;
        chk("miss pc held", bus.pc, 32'h40);
        chk("miss queue empty", bus.iq_valid, 32'd0);
        repeat (12) cycle();
        chk_log("miss req0", 0, 32'h40);
        chk_log("miss req1", 1, 32'h80);

        // Redirect arriving in the same cycle as the result.
        miss_lat = 3;
        for (int i = 0; i < 20 && resp_cnt != 1; i++) cycle();
        chk("coinc setup", resp_cnt, 32'd1);
        idx = req_log.size();
        bus.clear = 1'b1; bus.clear_pc = 32'h300;
        cycle();
        bus.clear = 1'b0;
        miss_lat = 1;
        chk("coinc queue empty", bus.iq_valid, 32'd0);
        chk("coinc pc", bus.pc, 32'h300);
        repeat (4) cycle();
        chk_log("coinc req", idx, 32'h300);

        // Global stall.
        rdy = 1'b0;
        repeat (3) cycle();
        rdy = 1'b1;
        repeat (2) cycle();

        // Asynchronous reset in the middle of a miss with a partly full queue.
        repeat (4) cycle();
        miss_lat = 10;
        for (int i = 0; i < 10 && resp_cnt < 8; i++) cycle();
        chk("pre-reset queue", bus.iq_valid, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        m_wait = 1'b0; m_pend = 1'b0; m_pc = RESET_PC; mq.delete();
        resp_cnt = 0; miss_lat = 1; bus.have_result = 1'b0;
        @(negedge clk);
        #1;
        chk_reset_outputs("reset held");
        rst = 1'b1;
        req_log.delete();
        repeat (4) cycle();
        chk_log("post-reset req0", 0, RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
